alu_seq: RTL



---
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on both sides.
// Returns one registered result with zero and signed-overflow flags per accepted op.
// Optional feature: define ALU_SEQ_MUL_EN to build the iterative shift-add
// multiplier (opcode 1100, WIDTH cycles per product). Without it, 1100 is an
// unknown opcode and yields 0 after one cycle.
module alu_seq #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1101;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic             r_outValid;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH:0]   w_sltDiff;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_aluOverflow;

  logic             w_accept;
  logic             w_isIdle;
  logic             w_load;
  logic [WIDTH-1:0] w_loadResult;
  logic             w_loadOverflow;

  // The sign-extended (WIDTH+1)-bit difference gives a correct slt even when
  // a-b overflows; its low WIDTH bits are the ordinary subtraction result.
  assign w_sum     = a + b;
  assign w_sltDiff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign w_diff    = w_sltDiff[WIDTH-1:0];
  assign w_shamt   = b[SHAMT_W-1:0];

  assign w_accept  = in_valid && in_ready;
  assign in_ready  = w_isIdle && (!r_outValid || out_ready);

  // Single-cycle ALU operations and their overflow flag.
  always_comb begin
    w_aluResult   = '0;
    w_aluOverflow = 1'b0;
    case (aluop)
      OP_ADD: begin
        w_aluResult   = w_sum;
        w_aluOverflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_aluResult   = w_diff;
        w_aluOverflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_aluResult = a & b;
      OP_OR:   w_aluResult = a | b;
      OP_XOR:  w_aluResult = a ^ b;
      OP_NOR:  w_aluResult = ~(a | b);
      OP_SLL:  w_aluResult = a << w_shamt;
      OP_SRL:  w_aluResult = a >> w_shamt;
      OP_SRA:  w_aluResult = $signed(a) >>> w_shamt;
      OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, w_sltDiff[WIDTH]};
      OP_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (a < b)};
      default: w_aluResult = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_mulA;
  logic [WIDTH-1:0] r_mulB;
  logic [WIDTH-1:0] r_acc;
  logic [SHAMT_W-1:0] r_count;
  logic [WIDTH-1:0] w_accNext;
  logic             w_isMulOp;
  logic             w_mulStart;
  logic             w_mulLast;

  // Only the low WIDTH bits of the product are kept, so the multiplicand
  // simply shifts out of range as the multiplier bits are consumed.
  assign w_accNext  = r_acc + (r_mulB[0] ? r_mulA : '0);
  assign w_isMulOp  = (aluop == OP_MUL);
  assign w_mulStart = w_accept && w_isMulOp;
  assign w_mulLast  = (r_count == SHAMT_W'(WIDTH - 1));
  assign w_isIdle   = (r_state == S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next state and output-register load selection.
  always_comb begin
    w_nextState    = r_state;
    w_load         = 1'b0;
    w_loadResult   = w_aluResult;
    w_loadOverflow = w_aluOverflow;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_isMulOp) w_nextState = S_MUL;
          else           w_load      = 1'b1;
        end
      end
      S_MUL: begin
        if (w_mulLast) begin
          w_load         = 1'b1;
          w_loadResult   = w_accNext;
          w_loadOverflow = 1'b0;
          w_nextState    = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Shift-add multiplier datapath: one partial product per cycle in MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mulA  <= '0;
      r_mulB  <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_mulStart) begin
      r_mulA  <= a;
      r_mulB  <= b;
      r_acc   <= '0;
      r_count <= '0;
    end else if (r_state == S_MUL) begin
      r_mulA  <= r_mulA << 1;
      r_mulB  <= r_mulB >> 1;
      r_acc   <= w_accNext;
      r_count <= r_count + SHAMT_W'(1);
    end
  end
`else
  assign w_isIdle       = 1'b1;
  assign w_load         = w_accept;
  assign w_loadResult   = w_aluResult;
  assign w_loadOverflow = w_aluOverflow;
`endif

  // One-entry output register: a load wins over a drain, otherwise a drain empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_outValid <= 1'b0;
    end else if (w_load) begin
      r_result   <= w_loadResult;
      r_zero     <= (w_loadResult == '0);
      r_overflow <= w_loadOverflow;
      r_outValid <= 1'b1;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign out_valid = r_outValid;

endmodule
